// File: rtl/par8_cmd_ctrl_pkg.sv
// Shared definitions for the parallel-bus command sequencer: opcodes,
// response bytes, bus sync bytes and the sequencer state encoding.
package par8_cmd_ctrl_pkg;

  // Command opcodes received from the parallel-bus receiver
  localparam logic [7:0] OP_PING        = 8'h01;
  localparam logic [7:0] OP_WRITE       = 8'h02;
  localparam logic [7:0] OP_READ        = 8'h03;
  localparam logic [7:0] OP_START       = 8'h04;
  localparam logic [7:0] OP_STATUS      = 8'h05;
  localparam logic [7:0] OP_DESYNC      = 8'h06;
  localparam logic [7:0] OP_READ_RESULT = 8'h07;

  // Response bytes sent back through the transmitter
  localparam logic [7:0] ACK_BYTE = 8'hA5;
  localparam logic [7:0] NAK_BYTE = 8'hEE;

  // Sync pattern the bus endpoints use to re-align after a desync
  localparam logic [7:0] SYNC_BYTE_0 = 8'h55;
  localparam logic [7:0] SYNC_BYTE_1 = 8'hAA;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARG1     = 3'd1,
    ST_ARG2     = 3'd2,
    ST_EXEC     = 3'd3,
    ST_TX_WAIT  = 3'd4,
    ST_TX_PULSE = 3'd5,
    ST_TX_GAP   = 3'd6,
    ST_RES_WAIT = 3'd7
  } state_t;

  // Opcodes that carry at least one argument byte (address)
  function automatic logic needs_args(input logic [7:0] op);
    return (op == OP_WRITE) || (op == OP_READ);
  endfunction

  // Opcodes the sequencer knows how to execute
  function automatic logic is_known_opcode(input logic [7:0] op);
    return (op >= OP_PING) && (op <= OP_READ_RESULT);
  endfunction

endpackage

// File: rtl/par8_cmd_ctrl_cmd_timeout.sv
// Idle-time watchdog: restarts at TIMEOUT_CYCLES on clear, counts down
// while enabled, and flags expiry once the count reaches zero.
module par8_cmd_ctrl_cmd_timeout
  import par8_cmd_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] r_count;

  // Reload on clear, otherwise count idle cycles down to zero and hold there
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_count <= LOAD_VAL;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/par8_cmd_ctrl.sv
// Command sequencer between the 8-bit parallel-bus endpoints and the MD5
// core. Parses opcode/argument bytes, executes register, core-control,
// status and result-drain commands, and paces response bytes out.
//
// Handshakes: i_rxd_data_ready is a one-cycle strobe qualifying i_rxd_data.
// o_txd_valid is a one-cycle registered strobe issued only in the cycle
// after i_txd_ready was sampled high; o_txd_data holds until the next
// strobe. i_result_valid marks i_result_data as available; the byte is
// latched when i_result_valid is sampled and o_result_ready pops it one
// cycle later as a single-cycle strobe.
module par8_cmd_ctrl
  import par8_cmd_ctrl_pkg::*;
#(
  parameter int NUM_REGS       = 4,
  parameter int RESULT_LEN     = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            i_rxd_data,
  input  logic                  i_rxd_data_ready,
  output logic                  o_desync,
  output logic [7:0]            o_txd_data,
  output logic                  o_txd_valid,
  input  logic                  i_txd_ready,
  output logic                  o_core_start,
  input  logic                  i_core_busy,
  input  logic                  i_core_done,
  input  logic [7:0]            i_result_data,
  input  logic                  i_result_valid,
  output logic                  o_result_ready,
  output logic [NUM_REGS*8-1:0] o_cfg_regs,
  output logic [3:0]            o_err_count,
  output logic [2:0]            o_dbg_state
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int RW = $clog2(RESULT_LEN + 1);

  state_t          r_state;
  logic [7:0]      r_opcode;
  logic [AW-1:0]   r_addr;
  logic [7:0]      r_wdata;
  logic [7:0]      r_tx_byte;
  logic [7:0]      r_txd_data;
  logic            r_txd_valid;
  logic            r_core_start;
  logic            r_desync;
  logic            r_result_ready;
  logic [RW-1:0]   r_remaining;
  logic [7:0]      r_cfg [NUM_REGS];
  logic [3:0]      r_err_count;

  logic w_wait;
  logic w_arg_state;
  logic w_tmo_clear;
  logic w_tmo_expired;
  logic w_busy_strobe;
  logic w_bad_op;
  logic w_tmo_err;
  logic w_err_inc;

  // Classify the current state and collect every error source into one increment
  always_comb begin
    w_arg_state   = (r_state == ST_ARG1) || (r_state == ST_ARG2);
    w_wait        = w_arg_state || (r_state == ST_RES_WAIT);
    // Restart the idle timer outside wait states and whenever an argument arrives
    w_tmo_clear   = !w_wait || (w_arg_state && i_rxd_data_ready);
    w_busy_strobe = i_rxd_data_ready &&
                    ((r_state == ST_EXEC) || (r_state == ST_TX_WAIT) ||
                     (r_state == ST_TX_PULSE) || (r_state == ST_TX_GAP) ||
                     (r_state == ST_RES_WAIT));
    w_bad_op      = (r_state == ST_EXEC) && !is_known_opcode(r_opcode);
    w_tmo_err     = w_tmo_expired &&
                    ((w_arg_state && !i_rxd_data_ready) ||
                     ((r_state == ST_RES_WAIT) && !i_result_valid));
    w_err_inc     = w_busy_strobe || w_bad_op || w_tmo_err;
  end

  par8_cmd_ctrl_cmd_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_tmo_clear),
    .i_en      (w_wait),
    .o_expired (w_tmo_expired)
  );

  // Command sequencer FSM with registered pulses, config registers and error counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_opcode       <= '0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_tx_byte      <= '0;
      r_txd_data     <= '0;
      r_txd_valid    <= 1'b0;
      r_core_start   <= 1'b0;
      r_desync       <= 1'b0;
      r_result_ready <= 1'b0;
      r_remaining    <= '0;
      r_err_count    <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_cfg[i] <= '0;
      end
    end else begin
      r_txd_valid    <= 1'b0;
      r_core_start   <= 1'b0;
      r_desync       <= 1'b0;
      r_result_ready <= 1'b0;

      if (w_err_inc && (r_err_count != 4'hF)) begin
        r_err_count <= r_err_count + 4'd1;
      end

      case (r_state)
        ST_IDLE: begin
          if (i_rxd_data_ready) begin
            r_opcode <= i_rxd_data;
            r_state  <= needs_args(i_rxd_data) ? ST_ARG1 : ST_EXEC;
          end
        end
        ST_ARG1: begin
          if (i_rxd_data_ready) begin
            r_addr  <= i_rxd_data[AW-1:0];
            r_state <= (r_opcode == OP_WRITE) ? ST_ARG2 : ST_EXEC;
          end else if (w_tmo_expired) begin
            r_state <= ST_IDLE;
          end
        end
        ST_ARG2: begin
          if (i_rxd_data_ready) begin
            r_wdata <= i_rxd_data;
            r_state <= ST_EXEC;
          end else if (w_tmo_expired) begin
            r_state <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          r_state   <= ST_TX_WAIT;
          r_tx_byte <= NAK_BYTE;
          case (r_opcode)
            OP_PING: r_tx_byte <= ACK_BYTE;
            OP_WRITE: begin
              r_cfg[r_addr] <= r_wdata;
              r_tx_byte     <= ACK_BYTE;
            end
            OP_READ: r_tx_byte <= r_cfg[r_addr];
            OP_START: begin
              if (!i_core_busy) begin
                r_core_start <= 1'b1;
                r_tx_byte    <= ACK_BYTE;
              end
            end
            OP_STATUS: r_tx_byte <= {i_core_busy, i_core_done, 2'b00, r_err_count};
            OP_DESYNC: begin
              r_desync <= 1'b1;
              r_state  <= ST_IDLE;
            end
            OP_READ_RESULT: begin
              r_remaining <= RW'(RESULT_LEN);
              r_state     <= ST_RES_WAIT;
            end
            default: r_tx_byte <= NAK_BYTE;
          endcase
        end
        ST_TX_WAIT: begin
          if (i_txd_ready) begin
            r_txd_valid <= 1'b1;
            r_txd_data  <= r_tx_byte;
            r_state     <= ST_TX_PULSE;
          end
        end
        ST_TX_PULSE: r_state <= ST_TX_GAP;
        ST_TX_GAP: r_state <= (r_remaining != '0) ? ST_RES_WAIT : ST_IDLE;
        ST_RES_WAIT: begin
          if (i_result_valid) begin
            r_result_ready <= 1'b1;
            r_tx_byte      <= i_result_data;
            r_remaining    <= r_remaining - RW'(1);
            r_state        <= ST_TX_WAIT;
          end else if (w_tmo_expired) begin
            // Abandon the drain: report NAK and drop the remaining bytes
            r_tx_byte   <= NAK_BYTE;
            r_remaining <= '0;
            r_state     <= ST_TX_WAIT;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Flatten the config register file onto the output bus
  always_comb begin
    o_cfg_regs = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      o_cfg_regs[8*i +: 8] = r_cfg[i];
    end
  end

  assign o_desync       = r_desync;
  assign o_txd_data     = r_txd_data;
  assign o_txd_valid    = r_txd_valid;
  assign o_core_start   = r_core_start;
  assign o_result_ready = r_result_ready;
  assign o_err_count    = r_err_count;
  assign o_dbg_state    = r_state;

endmodule

// File: doc/par8_cmd_ctrl.md
# par8_cmd_ctrl

Command sequencer between the 8-bit parallel-bus endpoints (receiver/transmitter) and the MD5 core. It parses opcode and argument bytes from the receiver and executes register writes/reads, core start, status and result-drain commands. It paces response bytes into the transmitter and issues bus desync. It is the only block that drives the transmitter and the core control inputs.

## Interface
- NUM_REGS, 4: number of 8-bit config registers (power of 2, ≤256)
- RESULT_LEN, 16: bytes drained per READ_RESULT
- TIMEOUT_CYCLES, 1000000: max idle cycles between argument bytes or result bytes; counter width = clog2(TIMEOUT_CYCLES+1)

- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- rxd_data  in  8  byte from receiver
- rxd_data_ready  in  1  one-cycle strobe, rxd_data valid
- desync  out  1  one-cycle pulse to receiver
- txd_data  out  8  byte to transmitter
- txd_valid  out  1  one-cycle registered strobe
- txd_ready  in  1  transmitter ready_next
- core_start  out  1  one-cycle pulse
- core_busy, core_done  in  1 each  core status
- result_data  in  8  core result byte
- result_valid  in  1  result byte available
- result_ready  out  1  one-cycle pop strobe
- cfg_regs  out  NUM_REGS*8  config registers, reg i at [8i+7:8i]
- err_count  out  4  saturating error counter

## Operation
- Opcodes: 0x01 PING → ACK 0xA5; 0x02 WRITE addr,data → write cfg_regs[addr mod NUM_REGS], ACK; 0x03 READ addr → cfg byte; 0x04 START → core_start pulse, ACK (NAK 0xEE if core_busy, no pulse); 0x05 STATUS → {core_busy, core_done, 2'b00, err_count}; 0x06 DESYNC → desync pulse, no response; 0x07 READ_RESULT → RESULT_LEN result bytes; any other byte → NAK, err_count+1.
- States: IDLE, ARG1, ARG2, EXEC, TX_WAIT, TX_PULSE, TX_GAP, RES_WAIT.
- IDLE: rxd strobe latches opcode; 0x02 → ARG1 → ARG2; 0x03 → ARG1; others → EXEC.
- EXEC: performs action, loads tx byte, → TX_WAIT (DESYNC → IDLE).
- TX_WAIT: waits txd_ready=1 → TX_PULSE (txd_valid=1, txd_data=byte) → TX_GAP (one cycle) → IDLE, or RES_WAIT if result bytes remain.
- RES_WAIT: result_valid=1 → result_ready pulse, latch result_data, → TX_WAIT.
- Timeout: ARG1/ARG2/RES_WAIT counter reaches TIMEOUT_CYCLES → err_count+1. In ARG states → IDLE, no response. In RES_WAIT → send NAK, then IDLE; remaining bytes abandoned.
- rxd strobe in any TX_*/RES_WAIT/EXEC state: byte discarded, err_count+1.
- err_count saturates at 15; cleared only by reset. Simultaneous increments in one cycle count once.

## Timing
- Reset: all outputs 0, cfg_regs 0, err_count 0, state IDLE.
- core_start, desync, cfg write: asserted in EXEC, i.e. the 2nd cycle after the final command-byte strobe.
- First txd_valid: no earlier than the 3rd cycle after the final command-byte strobe. It is asserted only in the cycle following a sampled txd_ready=1.
- txd_valid and result_ready are never high for two consecutive cycles. Consecutive txd_valid pulses are separated by ≥2 cycles.
- txd_data holds its value from TX_PULSE until the next TX_PULSE.
- Reset mid-command/mid-drain: immediate return to IDLE; no further pulses.

## Structure
- Shared include par_bus_defs: opcode constants, ACK/NAK values, sync bytes.
- Sub-module cmd_timeout: loadable down-counter with clear/enable/expired, used for both the argument and result timeouts.

## Test plan
- Reset, then PING (0x01) with txd_ready=1 → one txd_valid, txd_data=0xA5; err_count=0.
- WRITE 0x02,0x01,0x5C, then READ 0x03,0x01 → cfg_regs[15:8]=0x5C; responses 0xA5 then 0x5C.
- START with core_busy=0 → one core_start pulse + ACK. With core_busy=1 → no pulse, NAK 0xEE, err_count unchanged.
- READ_RESULT, core supplies 16 bytes 0x00..0x0F with txd_ready toggling → 16 txd_valid in order, 16 result_ready pulses, never back-to-back.
- READ_RESULT with result_valid stuck low → after TIMEOUT_CYCLES (bench uses 100): NAK 0xEE, err_count=1, IDLE.
- Opcode 0x99 → NAK, err_count=1. Then 20 more bad opcodes → err_count=15 (saturated). DESYNC → single desync pulse, no txd_valid.
